// File: rtl/imem_load_fetch_ctrl.sv
// Instruction-memory controller: boot-time program load, zero-fill of unused words,
// then single-cycle registered fetch service with misalignment/range fault reporting.
module imem_load_fetch_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_ready,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  output logic          fault,
  output logic          cpu_run,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_W    = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] WP_ONE    = (AW+1)'(1);
  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);

  state_e        state_q, state_d;
  logic [AW:0]   wp_q, wp_d;
  logic          ld_ready_q;
  logic          fetch_ready_q;
  logic          cpu_run_q;
  logic          instr_valid_q;
  logic          fault_q;
  logic          rd_pend_q;
  logic [DW-1:0] instr_q, instr_d;

  logic ld_hs;
  logic fetch_acc;
  logic addr_bad;

  // ld_ready_q is only ever high while in LOAD, so it alone qualifies the handshake.
  assign ld_hs     = ld_valid && ld_ready_q;
  assign fetch_acc = fetch_req && fetch_ready_q;

  // Full word index is compared so that any set high address bit faults instead of aliasing.
  assign addr_bad  = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:2] >= DEPTH_IDX);

  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    mem_we    = 1'b0;
    mem_waddr = wp_q[AW-1:0];
    mem_wdata = ld_data;
    case (state_q)
      ST_LOAD: begin
        if (ld_hs) begin
          mem_we = 1'b1;
          wp_d   = wp_q + WP_ONE;
          if (ld_last || (wp_q == LAST_W)) begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        mem_wdata = '0;
        if (wp_q < DEPTH_W) begin
          mem_we = 1'b1;
          wp_d   = wp_q + WP_ONE;
        end
        // Leave on the cycle that writes the last word, or at once if load filled the array.
        if (wp_d >= DEPTH_W) begin
          state_d = ST_RUN;
        end
      end
      default: begin
      end
    endcase
  end

  assign mem_re    = fetch_acc && !addr_bad;
  assign mem_raddr = fetch_addr[AW+1:2];

  always_comb begin
    instr_d = instr_q;
    if (fetch_acc && addr_bad) begin
      instr_d = '0;
    end else if (rd_pend_q) begin
      instr_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOAD;
      wp_q          <= '0;
      ld_ready_q    <= 1'b0;
      fetch_ready_q <= 1'b0;
      cpu_run_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      rd_pend_q     <= 1'b0;
      instr_q       <= '0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      ld_ready_q    <= (state_d == ST_LOAD);
      fetch_ready_q <= (state_d == ST_RUN);
      cpu_run_q     <= (state_d == ST_RUN);
      instr_valid_q <= fetch_acc;
      fault_q       <= fetch_acc && addr_bad;
      rd_pend_q     <= mem_re;
      instr_q       <= instr_d;
    end
  end

  // RAM read data arrives the cycle after mem_re, so it is passed straight through then.
  assign instr       = rd_pend_q ? mem_rdata : instr_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;
  assign ld_ready    = ld_ready_q;
  assign fetch_ready = fetch_ready_q;
  assign cpu_run     = cpu_run_q;

endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// Randomized scoreboard bench for imem_load_fetch_ctrl with a behavioural RAM and program model.
module tb_imem_load_fetch_ctrl;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 32;

  logic          clk;
  logic          rst_n;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_ready;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          fault;
  logic          cpu_run;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  imem_load_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr(instr), .instr_valid(instr_valid), .fault(fault), .cpu_run(cpu_run),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External synchronous RAM
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_raddr];
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp;
  int n_bad;

  // Program currently being loaded: word i of the array is prog[i], or zero beyond it.
  logic [31:0] prog[$];
  logic [31:0] addr_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    bit          flt;
  } exp_t;
  exp_t sb[$];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return (idx < prog.size()) ? prog[idx] : 32'h0;
  endfunction

  // Monitor / scoreboard
  bit          resp_due;
  logic [31:0] last_instr;
  int          wr_count;
  int          hs_count;
  int          last_hs_cyc;
  bit          run_seen;
  exp_t        mon_e;
  bit          mon_flt;
  int          exp_delay;

  always @(negedge clk) begin
    if (!rst_n) begin
      check({ld_ready, fetch_ready, instr_valid, fault, cpu_run, mem_we, mem_re} == 7'b0 && instr == 0,
            "reset_outputs", {ld_ready, fetch_ready, instr_valid, fault, cpu_run, mem_we, mem_re}, 0);
      sb.delete();
      resp_due   = 1'b0;
      last_instr = 32'h0;
      wr_count   = 0;
      hs_count   = 0;
      run_seen   = 1'b0;
    end else begin
      check(instr_valid == resp_due, "instr_valid_timing", 32'(instr_valid), 32'(resp_due));
      if (instr_valid) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_response", instr, 0);
        end else begin
          mon_e = sb.pop_front();
          check(fault == mon_e.flt, "fault", 32'(fault), 32'(mon_e.flt));
          check(instr == mon_e.word, "instr", instr, mon_e.word);
          last_instr = mon_e.word;
          $display("fetch addr=0x%08h instr=0x%08h fault=%0d", mon_e.addr, instr, fault);
        end
      end else begin
        check(fault == 1'b0, "fault_idle", 32'(fault), 0);
        check(instr == last_instr, "instr_hold", instr, last_instr);
      end

      resp_due = 1'b0;
      if (fetch_req && fetch_ready) begin
        mon_flt = (fetch_addr % 4 != 0) || (fetch_addr >= 32'(4 * DEPTH));
        mon_e.addr = fetch_addr;
        mon_e.flt  = mon_flt;
        mon_e.word = mon_flt ? 32'h0 : model_word(int'(fetch_addr / 4));
        sb.push_back(mon_e);
        resp_due = 1'b1;
        check(mem_re == !mon_flt, "mem_re", 32'(mem_re), 32'(!mon_flt));
        if (!mon_flt) check(32'(mem_raddr) == fetch_addr / 4, "mem_raddr", 32'(mem_raddr), fetch_addr / 4);
      end else begin
        check(mem_re == 1'b0, "mem_re_idle", 32'(mem_re), 0);
      end
      check(!(mem_we && mem_re), "we_re_exclusive", {mem_we, mem_re}, 0);
      check(fetch_ready == cpu_run, "fetch_ready_run", 32'(fetch_ready), 32'(cpu_run));

      if (ld_valid && ld_ready) begin
        hs_count++;
        last_hs_cyc = cyc;
        check(mem_we == 1'b1, "ld_write_strobe", 32'(mem_we), 1);
      end
      if (mem_we) begin
        if (wr_count >= DEPTH) begin
          check(1'b0, "extra_write", 32'(mem_waddr), 32'(wr_count));
        end else begin
          check(32'(mem_waddr) == 32'(wr_count), "waddr", 32'(mem_waddr), 32'(wr_count));
          check(mem_wdata == model_word(wr_count), "wdata", mem_wdata, model_word(wr_count));
        end
        wr_count++;
      end

      if (cpu_run && !run_seen) begin
        run_seen  = 1'b1;
        exp_delay = ((DEPTH - hs_count) > 1 ? (DEPTH - hs_count) : 1) + 1;
        check(cyc - last_hs_cyc == exp_delay, "run_latency", 32'(cyc - last_hs_cyc), 32'(exp_delay));
        check(wr_count == DEPTH, "words_written", 32'(wr_count), 32'(DEPTH));
        $display("load done: %0d words loaded, cpu_run at cycle %0d", hs_count, cyc);
      end else if (run_seen) begin
        check(cpu_run == 1'b1, "run_sticky", 32'(cpu_run), 1);
      end
      if (cpu_run) check(ld_ready == 1'b0, "ld_ready_in_run", 32'(ld_ready), 0);
    end
  end

  // Stimulus
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; fetch_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive_load(input bit use_last, input bit gaps, input int stop_after);
    int i = 0;
    int guard = 0;
    int n = prog.size();
    while (i < n && i < stop_after && guard < 1000) begin
      @(posedge clk); #1;
      ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld_data  = prog[i];
      ld_last  = use_last && (i == n - 1);
      @(negedge clk);
      if (ld_valid && ld_ready) i++;
      guard++;
    end
    if (guard >= 1000) check(1'b0, "load_timeout", 32'(i), 32'(n));
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_run();
    int k = 0;
    while (!cpu_run && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!cpu_run) check(1'b0, "run_timeout", 0, 1);
  endtask

  task automatic fetch_list();
    for (int i = 0; i < addr_q.size(); i++) begin
      @(posedge clk); #1;
      fetch_req  = 1'b1;
      fetch_addr = addr_q[i];
    end
    @(posedge clk); #1;
    fetch_req = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic random_fetch(input int k);
    int r;
    logic [31:0] idx;
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      fetch_req = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 9);
      idx = 32'($urandom_range(0, DEPTH - 1));
      if (r < 6)       fetch_addr = idx * 4;
      else if (r == 6) fetch_addr = idx * 4 + 32'($urandom_range(1, 3));
      else if (r == 7) fetch_addr = 32'(4 * DEPTH) + 4 * 32'($urandom_range(0, 3));
      else if (r == 8) fetch_addr = $urandom;
      else             fetch_addr = (32'h1 << $urandom_range(8, 31)) | (idx * 4);
    end
    @(posedge clk); #1;
    fetch_req = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n;
    bit use_last;
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Three-word program, fetch requested throughout load/clear
    prog = {32'h20100000, 32'h20110000, 32'h08000008};
    fetch_req = 1'b1; fetch_addr = 32'h0;
    drive_load(1'b1, 1'b0, 1000);
    wait_run();
    addr_q = {32'h0, 32'h4, 32'h8, 32'h6, 32'h100, 32'h4000_0000, 32'hFC};
    fetch_list();

    // Full 64-word load without ld_last; a 65th word stays presented
    do_reset();
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
    drive_load(1'b0, 1'b0, 1000);
    ld_valid = 1'b1; ld_data = 32'hBAD0_BAD0;
    repeat (2) begin
      @(negedge clk);
      check(ld_ready == 1'b0, "ld_ready_after_full", 32'(ld_ready), 0);
    end
    wait_run();
    random_fetch(80);
    ld_valid = 1'b0;

    // Reset in the middle of a load, then a one-word reload
    do_reset();
    prog = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    drive_load(1'b1, 1'b0, 2);
    do_reset();
    prog = {32'hDEADBEEF};
    drive_load(1'b1, 1'b0, 1000);
    wait_run();
    addr_q = {32'h0, 32'h4, 32'hFC};
    fetch_list();

    // Random program lengths with loader gaps
    for (int t = 0; t < 4; t++) begin
      do_reset();
      n = $urandom_range(1, DEPTH);
      use_last = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      drive_load(use_last, 1'b1, 1000);
      wait_run();
      random_fetch(60);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_load_fetch_ctrl.md
Name: imem_load_fetch_ctrl

Overview:
- Controller for the MIPS instruction memory array. After reset it sequences a boot-time program load into the array word by word, then zero-fills (NOP) every unused word.
- Once loading is done it releases the CPU and serves PC fetch requests through a 1-cycle registered read path, flagging misaligned and out-of-range addresses.
- It owns all memory write and read strobes. The storage array is an external synchronous RAM (write on clk edge, registered read data one cycle after the address).

Parameters:
- DEPTH, 64, number of 32-bit instruction words in the array.
- AW, 6, word-index width; DEPTH <= 2**AW.
- DW, 32, instruction width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  loader presents a program word.
- ld_data  in  DW  program word.
- ld_last  in  1  marks the final program word; qualified by ld_valid.
- ld_ready  out  1  controller accepts a word when ld_valid && ld_ready.
- fetch_req  in  1  CPU fetch request.
- fetch_addr  in  32  byte address from the PC.
- fetch_ready  out  1  fetch accepted when fetch_req && fetch_ready.
- instr  out  DW  fetched instruction.
- instr_valid  out  1  instr/fault valid this cycle.
- fault  out  1  fetch error; qualified by instr_valid.
- cpu_run  out  1  high once the program is loaded and cleared.
- mem_we  out  1  RAM write enable.
- mem_waddr  out  AW  RAM write index.
- mem_wdata  out  DW  RAM write data.
- mem_re  out  1  RAM read enable.
- mem_raddr  out  AW  RAM read index.
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_re.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State goes to LOAD.
  - Write pointer wp = 0.
  - ld_ready=0, fetch_ready=0, instr=0, instr_valid=0, fault=0, cpu_run=0, mem_we=0, mem_re=0.
  - RAM contents are untouched. Reset mid-LOAD or mid-CLEAR restarts the load from index 0.
- FSM states: LOAD -> CLEAR -> RUN. RUN is left only by reset.
- LOAD:
  - ld_ready=1.
  - On each handshake: mem_we=1, mem_waddr=wp, mem_wdata=ld_data, wp<=wp+1 (combinational strobes, same cycle).
  - If ld_last is accepted, or the word is written at wp==DEPTH-1, go to CLEAR with wp = next index.
- CLEAR:
  - ld_ready=0.
  - Writes 32'd0 to wp each cycle, wp<=wp+1.
  - When wp reaches DEPTH (no write at DEPTH), go to RUN.
  - If LOAD filled all DEPTH words, CLEAR lasts exactly 1 cycle with no write.
- RUN:
  - cpu_run=1 and fetch_ready=1 from the first RUN cycle.
  - ld_valid is ignored and ld_ready=0.
- Fetch (RUN only). Accepted fetch in cycle N produces its response in cycle N+1 (latency 1, one result per accepted request, back-to-back accepted every cycle):
  - Misaligned (fetch_addr[1:0]!=0) or out of range (fetch_addr[31:2] >= DEPTH): no RAM read; cycle N+1 gives instr_valid=1, fault=1, instr=0.
  - Otherwise: mem_re=1, mem_raddr=fetch_addr[AW+1:2] in cycle N; cycle N+1 gives instr=mem_rdata, instr_valid=1, fault=0.
  - With no accepted fetch in cycle N: instr_valid=0 and fault=0 in N+1; instr holds its last value.
- Loader words presented after RUN never reach the RAM.
- mem_we and mem_re are never high in the same cycle. Writes occur only in LOAD/CLEAR, reads only in RUN.
- Width rule: wp is AW+1 bits so it can reach DEPTH without wrap. The range check uses the full fetch_addr[31:2], never truncated, so high-bit aliasing is a fault.

Test Plan:
- Load 3 words 0x20100000, 0x20110000, 0x08000008 (last on third) -> writes at 0,1,2; CLEAR writes 0 to indices 3..63 over 61 cycles; cpu_run rises the next cycle.
- Load 64 words with no ld_last -> word 64 is refused (ld_ready=0 after the 64th handshake); one CLEAR cycle with no write; cpu_run=1.
- RUN, back-to-back fetches 0x0, 0x4, 0x8 -> instr_valid on 3 consecutive cycles with those words, fault=0.
- Fetch 0x6 -> fault=1, instr=0, mem_re=0. Fetch 0x100 (index 64) -> fault=1. Fetch 0x4000_0000 -> fault=1.
- Assert rst_n low mid-LOAD after 2 words, then reload 1 word 0xDEADBEEF with ld_last -> index 0 = 0xDEADBEEF, indices 1..63 = 0; fetch 0x4 returns 0.
- fetch_req held high during LOAD/CLEAR -> fetch_ready=0, no mem_re and no instr_valid until the first RUN cycle.
